lcd_bus_ctrl: RTL and testbench
===============================

# lcd_bus_ctrl

HD44780 bus controller that owns the 8-bit character-LCD interface on the board. It issues the power-up initialisation sequence, then accepts one byte per valid/ready handshake from display writers, whether a command (rs=0) or a character (rs=1). For each byte it generates correctly timed setup, enable-pulse, hold and execution-wait phases. It replaces free-running enable toggling: writers never drive lcd_en directly and only see req_ready.

## Interface
- CLK_HZ, 25_000_000, system clock frequency; all phase lengths derive from it
- PWRUP_US, 40_000, wait after reset release before the first init command
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  writer has a byte
- req_rs  in  1  0 = command, 1 = data/character
- req_data  in  8  byte to write
- req_ready  out  1  controller idle and initialised; transfer accepted when req_valid & req_ready at a rising edge
- init_done  out  1  init sequence complete; stays high until reset
- lcd_rs  out  1  register select to the panel
- lcd_rw  out  1  tied 0; write-only, the busy flag is never read
- lcd_en  out  1  enable strobe
- lcd_data  out  8  D7..D0 to the panel

## Operation
- Derived cycle counts (clamp each to ≥1):
  - SETUP = CLK_HZ/10_000_000 + 1
  - EN = CLK_HZ/2_000_000
  - HOLD = SETUP
  - SHORT = CLK_HZ/25_000 (40 µs)
  - LONG = CLK_HZ*16/10_000 (1.6 ms)
  - PWR = CLK_HZ/1_000_000 * PWRUP_US
- States:
  - PWRUP: count PWR cycles, then go to SETUP with init index 0.
  - SETUP: en=0, lcd_rs/lcd_data driven with the current byte, SETUP cycles.
  - PULSE: en=1, EN cycles.
  - HOLD: en=0, HOLD cycles.
  - WAIT: LONG cycles if rs=0 and data ∈ {0x01,0x02,0x03}, else SHORT cycles. Then either the next init entry (to SETUP), IDLE if the init sequence or a user transfer has finished, or IDLE with init_done set after the last init entry.
  - IDLE: req_ready=1.
- Init sequence (all rs=0): 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- Byte capture: req_rs/req_data are captured into internal registers on the accepting edge. lcd_rs/lcd_data hold that value from SETUP until the next transfer's SETUP; they do not return to 0 in IDLE.
- Requester rule: req_rs/req_data may change freely while req_valid=0. Bytes presented while req_ready=0 are ignored, never queued.
- One shared down-counter (width sized for max(PWR, LONG)) times all phases.

## Timing
- Reset values, applied on the edge where rst_n=0 sampled: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, req_ready=0, init_done=0, state=PWRUP, counter reloaded.
- Reset mid-pulse: lcd_en low the following edge; the full PWRUP wait and init sequence restart.
- Accept edge is cycle 0:
  - lcd_data valid from cycle 1.
  - lcd_en high for cycles SETUP+1 .. SETUP+EN.
  - req_ready low from cycle 1 and high again at cycle SETUP+EN+HOLD+WAIT+1.
- Back-to-back transfers: at most one accept per IDLE entry. req_ready is high for at least one cycle between transfers.
- init_done and req_ready rise on the same edge.

## Structure
- Package lcd_pkg holds:
  - state enum
  - init-command constants (FUNC_8BIT_2L=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06, DDRAM_L1=0x80, DDRAM_L2=0xC0)
  - a function mapping CLK_HZ to each phase count
  - is_long_cmd()
- Sub-module lcd_init_rom: 3-bit index → {last, byte}, combinational.
- The existing display-text sequencer and bin2bcd become requesters of this block.

## Test plan
Default CLK_HZ gives SETUP=3, EN=12, HOLD=3, SHORT=1000, LONG=40000. The bench sets PWRUP_US=10 (PWR=250).
- Release reset, hold req_valid=0 → six en pulses carrying 0x38,0x38,0x38,0x0C,0x01,0x06 with rs=0, each en high exactly 12 cycles. init_done=req_ready=1 exactly 45358 cycles after the first edge with rst_n=1.
- After init, send rs=1 data 0x48 → lcd_rs=1, lcd_data=0x48 at cycle 1, en high cycles 4–15, req_ready high at cycle 1019.
- Send rs=0 data 0x01 → req_ready high at cycle 40019. Send rs=0 data 0x80 → req_ready high at cycle 1019.
- Hold req_valid=1 with changing bytes during a transfer → only the byte present on the accepting edge appears on lcd_data. The next accept occurs no earlier than the cycle after req_ready rises.
- Assert rst_n=0 during PULSE → lcd_en=0 and lcd_data=0x00 after the next edge. The init sequence is then fully replayed.
- Throughout all scenarios: lcd_rw is always 0, and lcd_data/lcd_rs never change while lcd_en=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state/phase types, HD44780 command bytes and phase timing helpers
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } lcd_state_t;

   typedef enum logic [2:0] {
      PH_SETUP,
      PH_EN,
      PH_HOLD,
      PH_SHORT,
      PH_LONG,
      PH_PWR
   } lcd_phase_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } init_entry_t;

   localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
   localparam logic [7:0] DISP_ON      = 8'h0C;
   localparam logic [7:0] CLEAR        = 8'h01;
   localparam logic [7:0] RETURN_HOME  = 8'h02;
   localparam logic [7:0] ENTRY_INC    = 8'h06;
   localparam logic [7:0] DDRAM_L1     = 8'h80;
   localparam logic [7:0] DDRAM_L2     = 8'hC0;

   // Number of clock cycles a phase lasts at a given clock rate, never less than one
   function automatic int phase_cycles(lcd_phase_t phase, int clk_hz, int pwrup_us);
      longint hz;
      longint n;
      hz = longint'(clk_hz);
      case (phase)
         PH_SETUP: n = hz / 10_000_000 + 1;
         PH_EN:    n = hz / 2_000_000;
         PH_HOLD:  n = hz / 10_000_000 + 1;
         PH_SHORT: n = hz / 25_000;
         PH_LONG:  n = hz * 16 / 10_000;
         PH_PWR:   n = (hz / 1_000_000) * longint'(pwrup_us);
         default:  n = 1;
      endcase
      if (n < 1) begin
         n = 1;
      end
      return int'(n);
   endfunction

   // Clear and return-home commands need the 1.6 ms execution time; everything else is short
   function automatic logic is_long_cmd(logic rs, logic [7:0] data);
      return (rs == 1'b0) && ((data == CLEAR) || (data == RETURN_HOME) || (data == 8'h03));
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: power-up command list for the panel, one entry per index with an end marker
module lcd_init_rom
   import lcd_pkg::*;
(
   input  logic [2:0]  index,
   output init_entry_t entry
);

   // Indices past the list read as a terminating empty entry
   always_comb begin
      entry = '{last: 1'b1, data: 8'h00};
      case (index)
         3'd0:    entry = '{last: 1'b0, data: FUNC_8BIT_2L};
         3'd1:    entry = '{last: 1'b0, data: FUNC_8BIT_2L};
         3'd2:    entry = '{last: 1'b0, data: FUNC_8BIT_2L};
         3'd3:    entry = '{last: 1'b0, data: DISP_ON};
         3'd4:    entry = '{last: 1'b0, data: CLEAR};
         3'd5:    entry = '{last: 1'b1, data: ENTRY_INC};
         default: entry = '{last: 1'b1, data: 8'h00};
      endcase
   end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: owns the 8-bit HD44780 bus, runs the init sequence, then writes one byte per handshake
module lcd_bus_ctrl
   import lcd_pkg::*;
#(
   parameter int CLK_HZ   = 25_000_000,
   parameter int PWRUP_US = 40_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int SETUP_CYC = phase_cycles(PH_SETUP, CLK_HZ, PWRUP_US);
   localparam int EN_CYC    = phase_cycles(PH_EN,    CLK_HZ, PWRUP_US);
   localparam int HOLD_CYC  = phase_cycles(PH_HOLD,  CLK_HZ, PWRUP_US);
   localparam int SHORT_CYC = phase_cycles(PH_SHORT, CLK_HZ, PWRUP_US);
   localparam int LONG_CYC  = phase_cycles(PH_LONG,  CLK_HZ, PWRUP_US);
   localparam int PWR_CYC   = phase_cycles(PH_PWR,   CLK_HZ, PWRUP_US);

   localparam int CNT_MAX = (PWR_CYC > LONG_CYC) ? PWR_CYC : LONG_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // The counter is loaded with length-1 and the phase ends on the cycle it reads zero
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(PWR_CYC - 1);

   lcd_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       init_idx;
   logic             init_last;
   init_entry_t      rom_entry;

   // init_idx always points at the next entry to load, so one ROM port serves both entry points
   lcd_init_rom u_init_rom (
      .index (init_idx),
      .entry (rom_entry)
   );

   // The busy flag is never read, so the bus is permanently in write direction
   assign lcd_rw = 1'b0;

   // Phase sequencer: power-up wait, init bytes and user bytes all share setup/pulse/hold/wait timing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_PWRUP;
         cnt       <= PWR_LD;
         init_idx  <= 3'd0;
         init_last <= 1'b0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
      end else begin
         case (state)
            ST_PWRUP: begin
               if (cnt == '0) begin
                  state     <= ST_SETUP;
                  cnt       <= SETUP_LD;
                  lcd_rs    <= 1'b0;
                  lcd_data  <= rom_entry.data;
                  init_last <= rom_entry.last;
                  init_idx  <= init_idx + 3'd1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_SETUP: begin
               if (cnt == '0) begin
                  state  <= ST_PULSE;
                  cnt    <= EN_LD;
                  lcd_en <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_PULSE: begin
               if (cnt == '0) begin
                  state  <= ST_HOLD;
                  cnt    <= HOLD_LD;
                  lcd_en <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (cnt == '0) begin
                  state <= ST_WAIT;
                  cnt   <= is_long_cmd(lcd_rs, lcd_data) ? LONG_LD : SHORT_LD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_WAIT: begin
               if (cnt == '0) begin
                  if (init_done || init_last) begin
                     state     <= ST_IDLE;
                     req_ready <= 1'b1;
                     init_done <= 1'b1;
                  end else begin
                     state     <= ST_SETUP;
                     cnt       <= SETUP_LD;
                     lcd_rs    <= 1'b0;
                     lcd_data  <= rom_entry.data;
                     init_last <= rom_entry.last;
                     init_idx  <= init_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= ST_SETUP;
                  cnt       <= SETUP_LD;
                  req_ready <= 1'b0;
                  lcd_rs    <= req_rs;
                  lcd_data  <= req_data;
               end
            end

            default: begin
               state     <= ST_PWRUP;
               cnt       <= PWR_LD;
               lcd_en    <= 1'b0;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: randomized self-checking bench for the HD44780 bus controller
module tb_lcd_bus_ctrl;

   localparam int CLK_HZ   = 25_000_000;
   localparam int PWRUP_US = 10;

   // Expected phase lengths computed directly from the timing rules
   localparam int T_SETUP = CLK_HZ / 10_000_000 + 1;
   localparam int T_EN    = CLK_HZ / 2_000_000;
   localparam int T_HOLD  = T_SETUP;
   localparam int T_SHORT = CLK_HZ / 25_000;
   localparam int T_LONG  = CLK_HZ * 16 / 10_000;
   localparam int T_PWR   = CLK_HZ / 1_000_000 * PWRUP_US;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;
   logic       init_done;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_data;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] init_bytes  [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
   logic       single_rs   [3] = '{1'b1, 1'b0, 1'b0};
   logic [7:0] single_data [3] = '{8'h48, 8'h01, 8'h80};

   // Pulse log and bus invariant counters filled by the monitor
   int         pulse_start_q [$];
   int         pulse_len_q   [$];
   logic [7:0] pulse_data_q  [$];
   logic       pulse_rs_q    [$];
   int         cur_start  = 0;
   logic       prev_en    = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   logic       prev_rs    = 1'b0;
   int         rw_errors  = 0;
   int         stable_errors = 0;
   bit         mon_on     = 1'b0;

   lcd_bus_ctrl #(
      .CLK_HZ   (CLK_HZ),
      .PWRUP_US (PWRUP_US)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .req_ready (req_ready),
      .init_done (init_done),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en),
      .lcd_data  (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: execution wait and total length of one byte on the bus
   function automatic int wait_cycles(logic rs, logic [7:0] data);
      if (rs == 1'b0 && data >= 8'h01 && data <= 8'h03) return T_LONG;
      return T_SHORT;
   endfunction

   function automatic int byte_cycles(logic rs, logic [7:0] data);
      return T_SETUP + T_EN + T_HOLD + wait_cycles(rs, data);
   endfunction

   // Monitor: logs every enable pulse and watches rw and bus stability while enable is high
   always @(negedge clk) begin
      if (mon_on) begin
         if (lcd_rw !== 1'b0) rw_errors++;
         if (lcd_en === 1'b1 && prev_en === 1'b1 &&
             (lcd_data !== prev_data || lcd_rs !== prev_rs)) stable_errors++;
         if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
            cur_start = cyc;
            pulse_start_q.push_back(cyc);
            pulse_data_q.push_back(lcd_data);
            pulse_rs_q.push_back(lcd_rs);
         end
         if (lcd_en !== 1'b1 && prev_en === 1'b1) pulse_len_q.push_back(cyc - cur_start);
      end
      prev_en   = lcd_en;
      prev_data = lcd_data;
      prev_rs   = lcd_rs;
   end

   task automatic clear_pulses();
      pulse_start_q.delete();
      pulse_len_q.delete();
      pulse_data_q.delete();
      pulse_rs_q.delete();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_rs    = 1'b0;
      req_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({lcd_en, lcd_rs, lcd_rw, req_ready, init_done} !== 5'b00000)
         $display("[TB] FAIL reset_ctrl: en/rs/rw/ready/done got %b, expected 00000",
                  {lcd_en, lcd_rs, lcd_rw, req_ready, init_done});
      else n_pass++;
      n_checks++;
      if (lcd_data !== 8'h00)
         $display("[TB] FAIL reset_data: got %h, expected 00", lcd_data);
      else n_pass++;
      mon_on = 1'b1;
   endtask

   task automatic test_reset_mid_pulse();
      int k;
      rst_n = 1'b1;
      k = 0;
      while (lcd_en !== 1'b1 && k < T_PWR + 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (lcd_en !== 1'b1)
         $display("[TB] FAIL first_pulse_seen: en got %b after %0d cycles, expected 1", lcd_en, k);
      else n_pass++;
      repeat (4) @(negedge clk);
      n_checks++;
      if (lcd_en !== 1'b1)
         $display("[TB] FAIL pulse_still_high: en got %b, expected 1", lcd_en);
      else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (lcd_en !== 1'b0)
         $display("[TB] FAIL midpulse_en: got %b, expected 0", lcd_en);
      else n_pass++;
      n_checks++;
      if (lcd_data !== 8'h00 || lcd_rs !== 1'b0)
         $display("[TB] FAIL midpulse_bus: data/rs got %h/%b, expected 00/0", lcd_data, lcd_rs);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b0 || init_done !== 1'b0)
         $display("[TB] FAIL midpulse_flags: ready/done got %b/%b, expected 0/0", req_ready, init_done);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_init();
      int c0, k, t, rel, exp_done;
      int exp_start [6];
      t = T_PWR;
      for (int i = 0; i < 6; i++) begin
         exp_start[i] = t + T_SETUP;
         t += byte_cycles(1'b0, init_bytes[i]);
      end
      exp_done = t;
      clear_pulses();
      rst_n = 1'b1;
      @(negedge clk);
      c0 = cyc;
      k = 0;
      while (init_done !== 1'b1 && k < exp_done + 200) begin
         @(negedge clk);
         k++;
      end
      rel = cyc - c0 + 1;
      n_checks++;
      if (init_done !== 1'b1 || rel != exp_done)
         $display("[TB] FAIL init_done_time: done=%b at cycle %0d, expected 1 at cycle %0d",
                  init_done, rel, exp_done);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1)
         $display("[TB] FAIL init_ready_with_done: got %b, expected 1", req_ready);
      else n_pass++;
      n_checks++;
      if (pulse_data_q.size() != 6 || pulse_len_q.size() != 6)
         $display("[TB] FAIL init_pulse_count: got %0d, expected 6", pulse_data_q.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (i >= pulse_data_q.size() || i >= pulse_len_q.size())
            $display("[TB] FAIL init_pulse_%0d: missing, expected byte %h", i, init_bytes[i]);
         else if (pulse_data_q[i] !== init_bytes[i] || pulse_rs_q[i] !== 1'b0 ||
                  pulse_len_q[i] != T_EN || pulse_start_q[i] - c0 + 1 != exp_start[i])
            $display("[TB] FAIL init_pulse_%0d: byte/rs/len/start got %h/%b/%0d/%0d, expected %h/0/%0d/%0d",
                     i, pulse_data_q[i], pulse_rs_q[i], pulse_len_q[i], pulse_start_q[i] - c0 + 1,
                     init_bytes[i], T_EN, exp_start[i]);
         else n_pass++;
      end
   endtask

   task automatic test_single_writes();
      int acc, k, rel, exp_ready;
      for (int t = 0; t < 3; t++) begin
         k = 0;
         while (req_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
         end
         clear_pulses();
         exp_ready = byte_cycles(single_rs[t], single_data[t]) + 1;
         req_valid = 1'b1;
         req_rs    = single_rs[t];
         req_data  = single_data[t];
         @(negedge clk);
         acc = cyc;
         req_valid = 1'b0;
         req_rs    = 1'($urandom);
         req_data  = 8'($urandom);
         n_checks++;
         if (lcd_data !== single_data[t] || lcd_rs !== single_rs[t])
            $display("[TB] FAIL write%0d_cycle1_bus: data/rs got %h/%b, expected %h/%b",
                     t, lcd_data, lcd_rs, single_data[t], single_rs[t]);
         else n_pass++;
         n_checks++;
         if (req_ready !== 1'b0 || lcd_en !== 1'b0)
            $display("[TB] FAIL write%0d_cycle1_ctrl: ready/en got %b/%b, expected 0/0",
                     t, req_ready, lcd_en);
         else n_pass++;
         k = 1;
         while (req_ready !== 1'b1 && k < exp_ready + 200) begin
            @(negedge clk);
            k++;
         end
         rel = cyc - acc + 1;
         n_checks++;
         if (req_ready !== 1'b1 || rel != exp_ready)
            $display("[TB] FAIL write%0d_ready_time: ready=%b at cycle %0d, expected 1 at cycle %0d",
                     t, req_ready, rel, exp_ready);
         else n_pass++;
         n_checks++;
         if (pulse_start_q.size() != 1 || pulse_len_q.size() != 1)
            $display("[TB] FAIL write%0d_pulse_count: got %0d, expected 1", t, pulse_start_q.size());
         else if (pulse_start_q[0] - acc + 1 != T_SETUP + 1 || pulse_len_q[0] != T_EN)
            $display("[TB] FAIL write%0d_pulse_window: start/len got %0d/%0d, expected %0d/%0d",
                     t, pulse_start_q[0] - acc + 1, pulse_len_q[0], T_SETUP + 1, T_EN);
         else n_pass++;
         n_checks++;
         if (lcd_data !== single_data[t] || lcd_rs !== single_rs[t])
            $display("[TB] FAIL write%0d_idle_hold: data/rs got %h/%b, expected %h/%b",
                     t, lcd_data, lcd_rs, single_data[t], single_rs[t]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_data [$];
      logic       exp_rs   [$];
      int         acc_cyc  [$];
      logic       r;
      logic [7:0] d;
      int         k;
      bit         done;
      k = 0;
      while (req_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      clear_pulses();
      done = 1'b0;
      k = 0;
      while (!done && k < 6000) begin
         r = 1'($urandom);
         d = 8'($urandom);
         if (!r && d <= 8'h03) d = d | 8'h40;
         if (exp_data.size() < 3) begin
            req_valid = 1'b1;
            req_rs    = r;
            req_data  = d;
            if (req_ready === 1'b1) begin
               exp_data.push_back(d);
               exp_rs.push_back(r);
               acc_cyc.push_back(cyc + 1);
            end
         end else if (req_ready === 1'b1) begin
            req_valid = 1'b0;
            done      = 1'b1;
         end else begin
            req_valid = 1'b1;
            req_rs    = r;
            req_data  = d;
         end
         @(negedge clk);
         k++;
      end
      req_valid = 1'b0;
      n_checks++;
      if (!done)
         $display("[TB] FAIL b2b_timeout: accepted %0d bytes in %0d cycles, expected 3 then idle",
                  exp_data.size(), k);
      else n_pass++;
      n_checks++;
      if (pulse_data_q.size() != exp_data.size())
         $display("[TB] FAIL b2b_pulse_count: got %0d, expected %0d", pulse_data_q.size(), exp_data.size());
      else n_pass++;
      for (int i = 0; i < exp_data.size(); i++) begin
         n_checks++;
         if (i >= pulse_data_q.size())
            $display("[TB] FAIL b2b_byte_%0d: missing, expected %h/%b", i, exp_data[i], exp_rs[i]);
         else if (pulse_data_q[i] !== exp_data[i] || pulse_rs_q[i] !== exp_rs[i])
            $display("[TB] FAIL b2b_byte_%0d: data/rs got %h/%b, expected %h/%b",
                     i, pulse_data_q[i], pulse_rs_q[i], exp_data[i], exp_rs[i]);
         else n_pass++;
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         n_checks++;
         if (acc_cyc[i] - acc_cyc[i-1] != byte_cycles(exp_rs[i-1], exp_data[i-1]) + 1)
            $display("[TB] FAIL b2b_gap_%0d: got %0d, expected %0d", i,
                     acc_cyc[i] - acc_cyc[i-1], byte_cycles(exp_rs[i-1], exp_data[i-1]) + 1);
         else n_pass++;
      end
   endtask

   task automatic test_bus_invariants();
      n_checks++;
      if (rw_errors != 0)
         $display("[TB] FAIL rw_low: got %0d cycles with rw!=0, expected 0", rw_errors);
      else n_pass++;
      n_checks++;
      if (stable_errors != 0)
         $display("[TB] FAIL bus_stable_during_en: got %0d changes, expected 0", stable_errors);
      else n_pass++;
   endtask

   initial begin
      $display("[TB] starting lcd_bus_ctrl bench");
      test_reset();
      test_reset_mid_pulse();
      test_init();
      test_single_writes();
      test_back_to_back();
      test_bus_invariants();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
